vga_scan_ctrl: RTL and testbench
================================

# vga_scan_ctrl

Raster timing and pixel-fetch controller for the pong display path. It sits directly upstream of the `vga_conduit` pins and drives `vga_conduit_CLK/HS/VS/BLANK/SYNC/R/G/B`. From the 50 MHz system clock it derives a 25 MHz pixel tick and scans a 640x480@60 frame. It issues per-pixel coordinate requests to the game renderer and pipelines the sync and blank signals so they line up with the renderer's RGB data.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48: horizontal porches and sync width, in ticks
- `V_ACTIVE`, 480: visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33: vertical porches and sync width, in lines
- `PIX_LATENCY`, 2: renderer latency in ticks, allowed range 1..4

Ports:
- `clk_clk` in 1: 50 MHz system clock
- `reset_reset_n` in 1: asynchronous, active-low reset
- `pix_req` out 1: one-clk strobe; the current position is in the active region
- `pix_x` out 10: current column, 0..799
- `pix_y` out 10: current line, 0..524
- `pix_rgb` in 12: renderer colour {R,G,B}, 4 bits each
- `frame_start` out 1: one-clk pulse on the tick where the counters wrap to (0,0)
- `vga_conduit_CLK` out 1: 25 MHz pixel clock
- `vga_conduit_HS` out 1: horizontal sync, active low
- `vga_conduit_VS` out 1: vertical sync, active low
- `vga_conduit_BLANK` out 1: blank, active low (0 = blanked)
- `vga_conduit_SYNC` out 1: constant 0 (no sync-on-green)
- `vga_conduit_R` / `_G` / `_B` out 4 each: colour

## Operation
Pixel tick:
- `phase` register toggles on every `clk_clk` edge.
- `tick = (phase == 1)`.
- `vga_conduit_CLK = phase`.
- All other state advances only on tick edges.

Counters:
- `hcnt` counts 0..H_TOTAL-1, H_TOTAL = 800.
- On the tick at `hcnt = 799`, `hcnt` wraps to 0 and `vcnt` increments.
- `vcnt` counts 0..524 and wraps to 0 on the tick where `hcnt = 799` and `vcnt = 524`.
- `pix_x = hcnt` and `pix_y = vcnt`, combinational from the counters.

Region decode, evaluated on the current counters:
- active = `hcnt < 640` and `vcnt < 480`
- hs_n = 0 when `hcnt` is in [656, 751]
- vs_n = 0 when `vcnt` is in [490, 491]
- All boundaries are derived from the parameters.

Renderer handshake:
- `pix_req = tick & active`.
- The renderer must present `pix_rgb` for (pix_x, pix_y) so it is valid at the tick edge PIX_LATENCY ticks after the request tick.
- The renderer has no backpressure; the block never stalls.

Alignment pipeline:
- {active, hs_n, vs_n} enter a delay line that is PIX_LATENCY-1 ticks deep.
- The output register captures the delay-line tail together with `pix_rgb` on the tick edge.
- R/G/B = `pix_rgb` when the delayed active bit is 1, otherwise 0. `pix_rgb` is ignored while blanked.
- BLANK = delayed active.

Reset (asynchronous assertion):
- `phase` = 0, `hcnt` = 0, `vcnt` = 0, delay line cleared to inactive.
- Outputs: HS = 1, VS = 1, BLANK = 0, RGB = 0, CLK = 0, `pix_req` = 0, `frame_start` = 0.
- Reset asserted mid-frame takes effect immediately, with no partial-line completion.
- After release, the scan restarts at (0,0).

## Timing
- After reset release, the first clk edge sets `phase` = 1. The second edge is the first tick: the counters leave (0,0) and `frame_start` pulses.
- `frame_start` pulses once per frame, 420,000 ticks = 840,000 clks.
- Output pins change only on tick edges, which are the falling edges of `vga_conduit_CLK`. They are stable at every rising edge of `vga_conduit_CLK`.
- Latency from position (h,v) being current to its HS/VS/BLANK/RGB appearing on the pins: PIX_LATENCY ticks.
- Line period: 800 ticks. HS low for 96 ticks. Active region: 640 ticks of BLANK = 1.
- Frame period: 525 lines. VS low for exactly 2 full lines (1600 ticks). BLANK = 0 throughout lines 480..524.
- Wrap-around: `hcnt` and `vcnt` wrap on the same tick edge. There is no extra idle tick between frames.

## Test plan
- Reset: hold `reset_reset_n` = 0 with `pix_rgb` = 12'hFFF -> HS = 1, VS = 1, BLANK = 0, RGB = 0, CLK = 0, `pix_req` = 0. Release -> first `frame_start` pulse on clk edge 2.
- Line timing: run 2 lines -> HS low for exactly 192 clks, starting 656 ticks after hcnt = 0 (accounting for the PIX_LATENCY offset); HS period 1600 clks; 640 `pix_req` strobes per visible line.
- Frame timing: run 1 frame -> VS low for 3200 clks, `frame_start` period 840,000 clks, 307,200 `pix_req` strobes per frame.
- Alignment: model a renderer returning {pix_x[3:0], pix_y[3:0], 4'hA} with PIX_LATENCY-tick delay -> the pins show the colour for (0,0) on the first BLANK = 1 tick, and the colour for (639,y) on the last active tick of each line.
- Blank masking: hold `pix_rgb` = 12'hFFF constantly -> RGB = 0 on every tick where BLANK = 0; RGB = F/F/F on all active ticks.
- Mid-frame reset, repeated with PIX_LATENCY = 1 and PIX_LATENCY = 4: assert reset at (300,200) -> all outputs return to their reset values in the same cycle; after release the scan restarts at (0,0), and the latency check from the alignment scenario still holds.

Source files
------------

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: 640x480@60 raster timing, pixel-request generation and
// sync/blank alignment to the renderer's RGB latency for the VGA conduit.
module vga_scan_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int PIX_LATENCY = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    input  logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        vga_conduit_CLK,
    output logic        vga_conduit_HS,
    output logic        vga_conduit_VS,
    output logic        vga_conduit_BLANK,
    output logic        vga_conduit_SYNC,
    output logic [3:0]  vga_conduit_R,
    output logic [3:0]  vga_conduit_G,
    output logic [3:0]  vga_conduit_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DLY     = PIX_LATENCY - 1;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
    } ctl_t;

    typedef struct packed {
        logic        hs_n;
        logic        vs_n;
        logic        blank_n;
        logic [11:0] rgb;
    } out_t;

    localparam ctl_t CTL_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};
    localparam out_t OUT_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0, rgb: 12'h000};

    logic       phase_q, phase_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    out_t       out_q, out_d;
    logic       tick;
    ctl_t       ctl_now;
    ctl_t       ctl_tail;

    // tick is the second half of each pixel period; everything but phase moves on it
    assign tick = phase_q;

    // region decode on the current position
    always_comb begin
        ctl_now        = CTL_IDLE;
        ctl_now.active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        ctl_now.hs_n   = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
        ctl_now.vs_n   = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
    end

    // phase toggle, raster counters and the aligned output register
    always_comb begin
        phase_d = ~phase_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        out_d   = out_q;
        if (tick) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
            out_d.hs_n    = ctl_tail.hs_n;
            out_d.vs_n    = ctl_tail.vs_n;
            out_d.blank_n = ctl_tail.active;
            out_d.rgb     = ctl_tail.active ? pix_rgb : 12'h000;
        end
    end

    // state registers; reset lands immediately, mid-line or not
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            phase_q <= 1'b0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            out_q   <= OUT_IDLE;
        end else begin
            phase_q <= phase_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            out_q   <= out_d;
        end
    end

    // control bits wait PIX_LATENCY-1 ticks so they meet the renderer's colour
    generate
        if (DLY > 0) begin : g_dly
            ctl_t dly_q [DLY];
            ctl_t dly_d [DLY];

            // shift the delay line on each tick
            always_comb begin
                dly_d = dly_q;
                if (tick) begin
                    dly_d[0] = ctl_now;
                    for (int i = 1; i < DLY; i++) begin
                        dly_d[i] = dly_q[i-1];
                    end
                end
            end

            // delay-line storage, cleared to blanked/no-sync
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    for (int i = 0; i < DLY; i++) begin
                        dly_q[i] <= CTL_IDLE;
                    end
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign ctl_tail = dly_q[DLY-1];
        end else begin : g_nodly
            assign ctl_tail = ctl_now;
        end
    endgenerate

    assign pix_req     = tick & ctl_now.active;
    assign frame_start = tick & (hcnt_q == 10'd0) & (vcnt_q == 10'd0);
    assign pix_x       = hcnt_q;
    assign pix_y       = vcnt_q;

    assign vga_conduit_CLK   = phase_q;
    assign vga_conduit_HS    = out_q.hs_n;
    assign vga_conduit_VS    = out_q.vs_n;
    assign vga_conduit_BLANK = out_q.blank_n;
    assign vga_conduit_SYNC  = 1'b0;
    assign vga_conduit_R     = out_q.rgb[11:8];
    assign vga_conduit_G     = out_q.rgb[7:4];
    assign vga_conduit_B     = out_q.rgb[3:0];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench: one full-size instance for line timing, three shrunken-raster
// instances (latency 1, 2, 4) checked every clock against a position-history model.
module tb_vga_scan_ctrl;

    localparam logic [47:0] RST_VEC = {9'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000,
                                       1'b0, 1'b0, 10'd0, 10'd0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rgb_white = 1'b1;

    always #10 clk = ~clk;

    // full-size instance
    logic       f_req, f_fs, f_clk, f_hs, f_vs, f_blank, f_sync;
    logic [9:0] f_x, f_y;
    logic [3:0] f_r, f_g, f_b;

    vga_scan_ctrl u_full (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .pix_req(f_req), .pix_x(f_x), .pix_y(f_y), .pix_rgb(12'hFFF),
        .frame_start(f_fs), .vga_conduit_CLK(f_clk), .vga_conduit_HS(f_hs),
        .vga_conduit_VS(f_vs), .vga_conduit_BLANK(f_blank), .vga_conduit_SYNC(f_sync),
        .vga_conduit_R(f_r), .vga_conduit_G(f_g), .vga_conduit_B(f_b)
    );

    // shrunken raster: H 8/2/3/2 (total 15), V 4/1/2/1 (total 8)
    logic        s_req [3], s_fs [3], s_clk [3], s_hs [3], s_vs [3], s_blank [3], s_sync [3];
    logic [9:0]  s_x [3], s_y [3];
    logic [11:0] s_rgb [3];
    logic [3:0]  s_r [3], s_g [3], s_b [3];

    for (genvar g = 0; g < 3; g++) begin : g_small
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        logic [11:0] ren_col;

        assign ren_col = rgb_white ? 12'hFFF : {s_x[g][3:0], s_y[g][3:0], 4'hA};

        if (L == 1) begin : g_ren0
            assign s_rgb[g] = ren_col;
        end else begin : g_ren
            logic [11:0] pipe_q [L-1];
            always @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < L-1; i++) pipe_q[i] <= 12'h000;
                end else if (s_clk[g]) begin
                    pipe_q[0] <= ren_col;
                    for (int i = 1; i < L-1; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign s_rgb[g] = pipe_q[L-2];
        end

        vga_scan_ctrl #(
            .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
            .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
            .PIX_LATENCY(L)
        ) u_small (
            .clk_clk(clk), .reset_reset_n(rst_n),
            .pix_req(s_req[g]), .pix_x(s_x[g]), .pix_y(s_y[g]), .pix_rgb(s_rgb[g]),
            .frame_start(s_fs[g]), .vga_conduit_CLK(s_clk[g]), .vga_conduit_HS(s_hs[g]),
            .vga_conduit_VS(s_vs[g]), .vga_conduit_BLANK(s_blank[g]),
            .vga_conduit_SYNC(s_sync[g]),
            .vga_conduit_R(s_r[g]), .vga_conduit_G(s_g[g]), .vga_conduit_B(s_b[g])
        );
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // model of the shrunken raster
    bit m_phase;
    int m_h, m_v, n_ticks, clk_cnt;
    int hist_h [5];
    int hist_v [5];

    task automatic model_reset();
        m_phase = 1'b0;
        m_h = 0;
        m_v = 0;
        n_ticks = 0;
        clk_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            hist_h[i] = 0;
            hist_v[i] = 0;
        end
    endtask

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    function automatic logic [47:0] exp_small(int lat);
        logic act, hs_n, vs_n, cact;
        logic [11:0] rgb;
        int ph, pv;
        act = 1'b0; hs_n = 1'b1; vs_n = 1'b1; rgb = 12'h000;
        if (n_ticks >= lat) begin
            ph = hist_h[lat];
            pv = hist_v[lat];
            act  = (ph < 8) && (pv < 4);
            hs_n = !((ph >= 10) && (ph <= 12));
            vs_n = !((pv >= 5) && (pv <= 6));
            if (act) rgb = rgb_white ? 12'hFFF : {4'(ph), 4'(pv), 4'hA};
        end
        cact = m_phase && (m_h < 8) && (m_v < 4);
        return {9'b0, m_phase, hs_n, vs_n, act, 1'b0, rgb, cact,
                m_phase && (m_h == 0) && (m_v == 0), 10'(m_h), 10'(m_v)};
    endfunction

    function automatic logic [47:0] small_act(int i);
        return {9'b0, s_clk[i], s_hs[i], s_vs[i], s_blank[i], s_sync[i], s_r[i], s_g[i], s_b[i],
                s_req[i], s_fs[i], s_x[i], s_y[i]};
    endfunction

    function automatic logic [47:0] full_act();
        return {9'b0, f_clk, f_hs, f_vs, f_blank, f_sync, f_r, f_g, f_b, f_req, f_fs, f_x, f_y};
    endfunction

    // scenario trackers
    bit phase_a = 1'b0;
    bit f_hs_prev = 1'b1;
    bit first_fs = 1'b0;
    int hs_low0 = 0, hs_fall1 = -1, hs_fall2 = -1, req_l0 = 0, req_l1 = 0;
    int fs_t1 = -1, fs_t2 = -1;
    int vs_low [3] = '{0, 0, 0};
    int req_w [3] = '{0, 0, 0};
    int fs_w [3] = '{0, 0, 0};
    bit seen_blank [3] = '{0, 0, 0};
    logic [11:0] first_rgb [3];

    task automatic track();
        if (phase_a) begin
            if (clk_cnt == 1) first_fs = f_fs;
            if (clk_cnt <= 1600 && !f_hs) hs_low0++;
            if (f_hs_prev && !f_hs) begin
                if (hs_fall1 < 0) hs_fall1 = clk_cnt;
                else if (hs_fall2 < 0) hs_fall2 = clk_cnt;
            end
            if (f_req) begin
                if (clk_cnt <= 1600) req_l0++;
                else if (clk_cnt <= 3200) req_l1++;
            end
            if (clk_cnt >= 481 && clk_cnt <= 1200) begin
                for (int i = 0; i < 3; i++) begin
                    if (!s_vs[i]) vs_low[i]++;
                    if (s_req[i]) req_w[i]++;
                    if (s_fs[i]) fs_w[i]++;
                end
            end
            if (s_fs[0]) begin
                if (fs_t1 < 0) fs_t1 = clk_cnt;
                else if (fs_t2 < 0) fs_t2 = clk_cnt;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (!seen_blank[i] && s_blank[i]) begin
                seen_blank[i] = 1'b1;
                first_rgb[i] = {s_r[i], s_g[i], s_b[i]};
            end
        end
        f_hs_prev = f_hs;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            clk_cnt++;
            if (m_phase) begin
                for (int i = 4; i > 0; i--) begin
                    hist_h[i] = hist_h[i-1];
                    hist_v[i] = hist_v[i-1];
                end
                if (m_h == 14) begin
                    m_h = 0;
                    m_v = (m_v == 7) ? 0 : m_v + 1;
                end else begin
                    m_h++;
                end
                hist_h[0] = m_h;
                hist_v[0] = m_v;
                n_ticks++;
            end
            m_phase = !m_phase;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pins_L%0d_clk%0d", lat_of(i), clk_cnt), small_act(i),
                  exp_small(lat_of(i)));
        end
        if (rst_n) track();
    endtask

    initial begin
        bit reached;
        model_reset();
        repeat (3) step();
        check("rst_full", full_act(), RST_VEC);
        #4 rst_n = 1'b1;
        phase_a = 1'b1;
        repeat (3300) step();
        phase_a = 1'b0;

        check("fs_first_tick", 48'(first_fs), 48'd1);
        check("hs_fall_first", 48'(hs_fall1), 48'd1316);
        check("hs_low_clks", 48'(hs_low0), 48'd192);
        check("hs_period", 48'(hs_fall2 - hs_fall1), 48'd1600);
        check("req_line0", 48'(req_l0), 48'd640);
        check("req_line1", 48'(req_l1), 48'd640);
        check("fs_period_small", 48'(fs_t2 - fs_t1), 48'd240);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("vs_low_L%0d", lat_of(i)), 48'(vs_low[i]), 48'd180);
            check($sformatf("req_frames_L%0d", lat_of(i)), 48'(req_w[i]), 48'd96);
            check($sformatf("fs_frames_L%0d", lat_of(i)), 48'(fs_w[i]), 48'd3);
            check($sformatf("first_blank_white_L%0d", lat_of(i)), 48'(first_rgb[i]), 48'hFFF);
        end

        reached = 1'b0;
        for (int k = 0; k < 300 && !reached; k++) begin
            step();
            if (m_h == 5 && m_v == 2) reached = 1'b1;
        end
        check("reach_5_2", 48'(reached), 48'd1);
        #4 rst_n = 1'b0;
        model_reset();
        rgb_white = 1'b0;
        #1;
        check("midrst_full", full_act(), RST_VEC);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midrst_L%0d", lat_of(i)), small_act(i), RST_VEC);
            seen_blank[i] = 1'b0;
        end
        repeat (4) step();
        #4 rst_n = 1'b1;
        repeat (500) step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("first_blank_pat_L%0d", lat_of(i)), 48'(first_rgb[i]), 48'h00A);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
